dino_jump_ctrl: RTL

Vertical-motion controller for the T-rex sprite. It turns a jump request into a per-frame vertical position by integrating velocity under constant gravity. It lands the sprite back on the ground line and reports airborne and landing status. It sits between the input debouncer and the sprite renderer, and advances once per video frame on `frame_tick`.

---
 rtl/dino_phys_pkg.sv | 16 +
 rtl/jump_integrator.sv | 65 ++++++
 rtl/dino_jump_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dino_phys_pkg.sv
// Shared sprite-physics types and widths for the T-rex motion, render and collision blocks.
package dino_phys_pkg;

    localparam int unsigned Y_W      = 11;
    localparam int unsigned VEL_W    = 11;
    localparam int unsigned CALC_W   = 12;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned VEL_LIM  = 1023;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } phys_state_e;

endpackage

// File: rtl/jump_integrator.sv
// Combinational per-frame integration step: short-hop cap, ceiling/ground clamps, velocity saturation.
module jump_integrator
    import dino_phys_pkg::*;
#(
    parameter int unsigned GROUND_Y = 300,
    parameter int unsigned INIT_VEL = 20,
    parameter int unsigned G        = 1,
    parameter int unsigned CUT_VEL  = 6
) (
    input  logic             launch,
    input  logic             rising,
    input  logic             falling,
    input  logic             jump_held,
    input  logic [Y_W-1:0]   y_cur,
    input  logic [VEL_W-1:0] vel_cur,
    output logic [Y_W-1:0]   y_nxt_c,
    output logic [VEL_W-1:0] vel_nxt_c,
    output logic             touchdown_c,
    output logic             ascend_c
);

    localparam logic signed [CALC_W-1:0] GROUND_S = CALC_W'(GROUND_Y);
    localparam logic signed [CALC_W-1:0] INIT_S   = CALC_W'(INIT_VEL);
    localparam logic signed [CALC_W-1:0] G_S      = CALC_W'(G);
    localparam logic signed [CALC_W-1:0] CUT_S    = CALC_W'(CUT_VEL);
    localparam logic signed [CALC_W-1:0] FLOOR_S  = CALC_W'(-int'(VEL_LIM));
    localparam logic signed [CALC_W-1:0] ZERO_S   = '0;

    logic signed [CALC_W-1:0] y_base;
    logic signed [CALC_W-1:0] v_base;
    logic signed [CALC_W-1:0] y_calc;
    logic signed [CALC_W-1:0] v_calc;

    // A launch is an ordinary step taken from the ground line at launch speed.
    always_comb begin
        y_base      = launch ? GROUND_S : $signed({1'b0, y_cur});
        v_base      = launch ? INIT_S   : $signed({vel_cur[VEL_W-1], vel_cur});
        touchdown_c = 1'b0;

        if (rising && !jump_held && (v_base > CUT_S)) begin
            v_base = CUT_S;
        end

        y_calc = y_base - v_base;
        v_calc = v_base - G_S;

        if (v_calc < FLOOR_S) begin
            v_calc = FLOOR_S;
        end

        if (y_calc < ZERO_S) begin
            y_calc = ZERO_S;
            v_calc = ZERO_S;
        end else if (falling && (y_calc >= GROUND_S)) begin
            y_calc      = GROUND_S;
            v_calc      = ZERO_S;
            touchdown_c = 1'b1;
        end

        y_nxt_c   = y_calc[Y_W-1:0];
        vel_nxt_c = v_calc[VEL_W-1:0];
        ascend_c  = (v_calc > ZERO_S);
    end

endmodule

// File: rtl/dino_jump_ctrl.sv
// T-rex vertical-motion controller: jump request capture, airborne FSM and registered y/vel outputs.
module dino_jump_ctrl
    import dino_phys_pkg::*;
#(
    parameter int unsigned GROUND_Y = 300,
    parameter int unsigned INIT_VEL = 20,
    parameter int unsigned G        = 1,
    parameter int unsigned CUT_VEL  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             jump,
    input  logic             freeze,
    output logic [Y_W-1:0]   y,
    output logic [VEL_W-1:0] vel,
    output logic             airborne,
    output logic             landed
);

    phys_state_e      state_q;
    phys_state_e      state_d;
    logic             jump_q;
    logic             jump_pend;
    logic             pend_d;
    logic [Y_W-1:0]   y_d;
    logic [VEL_W-1:0] vel_d;
    logic             airborne_d;
    logic             landed_d;

    logic             step;
    logic             jump_edge;
    logic [Y_W-1:0]   int_y;
    logic [VEL_W-1:0] int_vel;
    logic             int_touchdown;
    logic             int_ascend;

    assign step      = frame_tick && !freeze;
    assign jump_edge = jump && !jump_q;

    jump_integrator #(
        .GROUND_Y (GROUND_Y),
        .INIT_VEL (INIT_VEL),
        .G        (G),
        .CUT_VEL  (CUT_VEL)
    ) u_integrator (
        .launch      (state_q == GROUNDED),
        .rising      (state_q == RISING),
        .falling     (state_q == FALLING),
        .jump_held   (jump),
        .y_cur       (y),
        .vel_cur     (vel),
        .y_nxt_c     (int_y),
        .vel_nxt_c   (int_vel),
        .touchdown_c (int_touchdown),
        .ascend_c    (int_ascend)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= GROUNDED;
            y         <= Y_W'(GROUND_Y);
            vel       <= '0;
            airborne  <= 1'b0;
            landed    <= 1'b0;
            jump_q    <= 1'b0;
            jump_pend <= 1'b0;
        end else begin
            state_q   <= state_d;
            y         <= y_d;
            vel       <= vel_d;
            airborne  <= airborne_d;
            landed    <= landed_d;
            jump_q    <= jump;
            jump_pend <= pend_d;
        end
    end

    // Freeze blocks every update, so a pending request survives a paused tick.
    always_comb begin
        state_d  = state_q;
        y_d      = y;
        vel_d    = vel;
        pend_d   = jump_pend;
        landed_d = 1'b0;

        case (state_q)
            GROUNDED: begin
                if (!freeze && jump_edge) begin
                    pend_d = 1'b1;
                end
                if (step && (jump_pend || jump_edge)) begin
                    pend_d  = 1'b0;
                    y_d     = int_y;
                    vel_d   = int_vel;
                    state_d = int_ascend ? RISING : FALLING;
                end
            end
            RISING, FALLING: begin
                if (step) begin
                    y_d   = int_y;
                    vel_d = int_vel;
                    if (int_touchdown) begin
                        state_d  = GROUNDED;
                        landed_d = 1'b1;
                    end else begin
                        state_d = int_ascend ? RISING : FALLING;
                    end
                end
            end
            default: begin
                state_d = GROUNDED;
                y_d     = Y_W'(GROUND_Y);
                vel_d   = '0;
                pend_d  = 1'b0;
            end
        endcase

        airborne_d = (state_d != GROUNDED);
    end

endmodule
